// File: rtl/matrix_scan_driver_if.sv
// Bitmap handshake plus matrix pin bundle for the LED row-scan driver.
interface matrix_scan_driver_if;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_on;
  logic        frame_start;
  logic [2:0]  row_idx;

  // Bitmap source / pin observer side
  modport master (
    output frame_in, frame_valid,
    input  frame_ready, row_sel, col_on, frame_start, row_idx
  );

  // Scan driver side
  modport slave (
    input  frame_in, frame_valid,
    output frame_ready, row_sel, col_on, frame_start, row_idx
  );
endinterface

// File: rtl/matrix_scan_driver.sv
// Double-buffered 8x8 LED row-multiplexing driver with inter-row blanking.
// A frame lands in the pending buffer and is promoted to the display buffer
// only at the end of row 7, so a scan frame never shows a mix of bitmaps.
module matrix_scan_driver #(
  parameter int DWELL_CYCLES = 6250,
  parameter int BLANK_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  matrix_scan_driver_if.slave bus
);
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int PW   = $clog2(MAXC + 1);
  localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [2:0]    row;
  logic          run;        // low until the first edge after reset release
  logic [63:0]   pend;
  logic          pend_full;
  logic [63:0]   disp;
  logic          ready_q;
  logic [7:0]    row_sel_q;
  logic [7:0]    col_on_q;
  logic          fs_q;

  logic accept;
  logic frame_end;

  assign accept    = bus.frame_valid && ready_q;
  assign frame_end = run && (state == DRIVE) && (phase == DWELL_LAST) && (row == 3'd7);

  assign bus.frame_ready = ready_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.col_on      = col_on_q;
  assign bus.frame_start = fs_q;
  assign bus.row_idx     = row;

  // Pending/display buffering; swap and accept are exclusive since a swap
  // needs pend_full, which holds frame_ready low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
      disp      <= '0;
      ready_q   <= 1'b0;
    end else if (frame_end && pend_full) begin
      disp      <= pend;
      pend_full <= 1'b0;
      ready_q   <= 1'b1;
    end else if (accept) begin
      pend      <= bus.frame_in;
      pend_full <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      ready_q   <= ~pend_full;
    end
  end

  // Blank/drive scan FSM with registered pin outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BLANK;
      phase     <= '0;
      row       <= '0;
      run       <= 1'b0;
      row_sel_q <= '0;
      col_on_q  <= '0;
      fs_q      <= 1'b0;
    end else if (!run) begin
      // First edge after release opens the row 0 blank of frame 0.
      run   <= 1'b1;
      state <= BLANK;
      phase <= '0;
      row   <= '0;
      fs_q  <= 1'b1;
    end else begin
      fs_q <= 1'b0;
      case (state)
        BLANK: begin
          if (phase == BLANK_LAST) begin
            state     <= DRIVE;
            phase     <= '0;
            row_sel_q <= 8'b1 << row;
            col_on_q  <= disp[{row, 3'b000} +: 8];
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DRIVE: begin
          if (phase == DWELL_LAST) begin
            state     <= BLANK;
            phase     <= '0;
            row       <= row + 3'd1;
            row_sel_q <= '0;
            col_on_q  <= '0;
            fs_q      <= (row == 3'd7);
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          state     <= BLANK;
          phase     <= '0;
          row_sel_q <= '0;
          col_on_q  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: a timeline model of the scan checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_matrix_scan_driver;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int P  = B + D;
  localparam int FP = 8 * P;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  matrix_scan_driver_if bus();

  matrix_scan_driver #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: scan position follows from time since release; buffers from
  // accept/frame-boundary events.
  bit          m_started = 0;
  int          m_t       = 0;
  logic [63:0] m_pend    = '0;
  logic [63:0] m_disp    = '0;
  bit          m_pfull   = 0;
  bit          m_ready   = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_started = 0; m_t = 0; m_pfull = 0; m_ready = 0; m_disp = '0; m_pend = '0;
    end else begin
      automatic bit acc = bus.frame_valid && m_ready;
      if (!m_started) begin
        m_started = 1; m_t = 0;
      end else begin
        m_t++;
        if (m_t % FP == 0 && m_pfull) begin
          m_disp = m_pend; m_pfull = 0;
        end
      end
      if (acc) begin
        m_pend = bus.frame_in; m_pfull = 1;
      end
      m_ready = !m_pfull;
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    begin
      automatic logic [7:0] e_sel = '0;
      automatic logic [7:0] e_col = '0;
      automatic logic       e_fs  = 1'b0;
      automatic logic [2:0] e_row = '0;
      if (m_started) begin
        automatic int pos = m_t % P;
        automatic int r   = (m_t / P) % 8;
        e_row = 3'(r);
        e_fs  = (m_t % FP == 0);
        if (pos >= B) begin
          e_sel = 8'(1 << r);
          e_col = m_disp[r*8 +: 8];
        end
      end
      chk("row_sel", bus.row_sel, e_sel);
      chk("col_on", bus.col_on, e_col);
      chk("frame_start", bus.frame_start, e_fs);
      chk("row_idx", bus.row_idx, e_row);
      chk("frame_ready", bus.frame_ready, m_ready);
      chk("row_onehot", ($countones(bus.row_sel) <= 1), 1);
    end
  end

  task automatic wait_fs(input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_start;
    end
    if (!seen) chk(nm, 0, 1);
  endtask

  initial begin
    logic [63:0] data [3];
    int acc_cyc [3];
    int idx;
    bit acc, fs_prev, seen;
    int c0, c1, c2, zeros;

    bus.frame_in    = '0;
    bus.frame_valid = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_row_sel", bus.row_sel, 0);
    chk("rst_ready", bus.frame_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_fs", bus.frame_start, 1);
    chk("first_ready", bus.frame_ready, 1);

    // Single frame
    @(negedge clk);
    bus.frame_in = 64'hAA55_AA55_AA55_AA55; bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    chk("ready_drop", bus.frame_ready, 0);
    wait_fs("wait_fs_single");
    chk("ready_after_swap", bus.frame_ready, 1);
    repeat (2) @(negedge clk);
    chk("row0_col", bus.col_on, 8'h55);
    chk("row0_sel", bus.row_sel, 8'h01);
    repeat (6) @(negedge clk);
    chk("row1_col", bus.col_on, 8'hAA);
    chk("row1_sel", bus.row_sel, 8'h02);

    // Row timing
    wait_fs("wait_fs_t0"); c0 = cyc;
    @(negedge clk);
    wait_fs("wait_fs_t1"); c1 = cyc;
    @(negedge clk);
    wait_fs("wait_fs_t2"); c2 = cyc;
    chk("fs_spacing0", c1 - c0, FP);
    chk("fs_spacing1", c2 - c1, FP);

    // Back-to-back frames with valid held high
    data[0] = 64'h0102_0408_1020_4080;
    data[1] = 64'hFF00_FF00_FF00_FF00;
    data[2] = 64'h8001_8001_8001_8001;
    idx = 0; acc = 0; fs_prev = 0;
    for (int n = 0; n < 400 && idx < 3; n++) begin
      @(negedge clk);
      if (acc) begin
        if (idx == 1) chk("b_after_swap", fs_prev, 1);
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (idx < 3) begin
        bus.frame_in = data[idx]; bus.frame_valid = 1'b1;
      end else begin
        bus.frame_valid = 1'b0;
      end
      acc     = bus.frame_ready;
      fs_prev = bus.frame_start;
    end
    bus.frame_valid = 1'b0;
    chk("b2b_all_accepted", idx, 3);
    if (idx == 3) chk("c_stall", acc_cyc[2] - acc_cyc[1], FP);

    // Reset mid-operation during a row 3 drive
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.row_idx == 3'd3) && (bus.row_sel != 0);
    end
    chk("found_row3", seen, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_row_sel", bus.row_sel, 0);
    chk("async_col_on", bus.col_on, 0);
    chk("async_row_idx", bus.row_idx, 0);
    chk("async_ready", bus.frame_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart_fs", bus.frame_start, 1);
    repeat (2) @(posedge clk); #1;
    chk("restart_row0", bus.row_sel, 8'h01);
    chk("restart_blank_disp", bus.col_on, 8'h00);

    // No new data: one frame then repeat
    @(negedge clk);
    bus.frame_in = 64'h0123_4567_89AB_CDEF; bus.frame_valid = 1'b1;
    @(negedge clk);
    bus.frame_valid = 1'b0;
    wait_fs("wait_fs_repeat");
    zeros = 0;
    repeat (10 * FP) begin
      @(negedge clk);
      if (!bus.frame_ready) zeros++;
    end
    chk("ready_held", zeros, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
